// File: rtl/viterbi_pkg.sv
// Purpose : shared constants, trellis tables and metric helpers for the Viterbi decoder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Trellis tables are indexed by the next state. Branch 0 always comes from the
// lower-numbered predecessor, so "keep branch 0 on a tie" equals "keep the
// lower-index predecessor".
package viterbi_pkg;

  localparam int NUM_STATES   = 8;
  localparam int METRIC_W_MAX = 8;

  // Wide enough to hold an unsaturated PM + BM sum at any legal metric width.
  typedef logic [METRIC_W_MAX:0] metric_t;

  localparam logic [2:0] PRED0 [NUM_STATES] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6};
  localparam logic [2:0] PRED1 [NUM_STATES] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7};

  localparam logic PBIT0 [NUM_STATES] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic PBIT1 [NUM_STATES] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  localparam logic [1:0] PSYM0 [NUM_STATES] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
  localparam logic [1:0] PSYM1 [NUM_STATES] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};

  // Hamming distance between two 2-bit symbols, 0..2.
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Purpose : add-compare-select for one trellis state (two incoming branches).
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   pm0, pm1   path metrics of the lower / higher index predecessor
//   d_in       received symbol {c1,c0}
//   sym0, sym1 expected symbol on each incoming branch
//   pm_new     surviving candidate metric (saturated at all-ones)
//   sel        1 = higher-index predecessor won; ties go to the lower index
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int METRIC_W = 6
) (
  input  logic [METRIC_W-1:0] pm0,
  input  logic [METRIC_W-1:0] pm1,
  input  logic [1:0]          d_in,
  input  logic [1:0]          sym0,
  input  logic [1:0]          sym1,
  output logic [METRIC_W-1:0] pm_new,
  output logic                sel
);

  localparam metric_t SAT = metric_t'((1 << METRIC_W) - 1);

  metric_t             sum0;
  metric_t             sum1;
  logic [METRIC_W-1:0] cand0;
  logic [METRIC_W-1:0] cand1;

  always_comb begin
    sum0   = metric_t'(pm0) + metric_t'(hamming2(d_in, sym0));
    sum1   = metric_t'(pm1) + metric_t'(hamming2(d_in, sym1));
    cand0  = (sum0 > SAT) ? '1 : sum0[METRIC_W-1:0];
    cand1  = (sum1 > SAT) ? '1 : sum1[METRIC_W-1:0];
    // Strict compare: an equal metric keeps the lower-index predecessor.
    sel    = (cand1 < cand0);
    pm_new = sel ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Purpose : hard-decision 8-state rate-1/2 Viterbi decoder, register-exchange survivors.
// Latency : TB_DEPTH accepted symbols from symbol in to decoded bit out (registered).
// Backpressure: none; one symbol accepted per clock with enable_i, one bit out per clock once full.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   enable_i  symbol valid; low for a clock re-initialises the trellis (frame boundary)
//   d_in      received symbol {c1,c0}
//   valid_o   d_out holds a decoded bit
//   d_out     decoded bit, 0 whenever valid_o is 0
//
// Build option VITERBI_BEST_STATE_EN: decode from the state with the smallest
// path metric (lowest index on ties). Without it, state 0 is always used, which
// relies on zero-tailed frames.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int METRIC_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic [1:0] d_in,
  output logic       valid_o,
  output logic       d_out
);

  localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  logic [METRIC_W-1:0] pm   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv [NUM_STATES];
  logic [FILL_W-1:0]   fill;
  logic                full;
  logic [2:0]          sel_state;

  // Minimum of the pre-update metrics; feeds normalisation (and state selection).
  logic [METRIC_W-1:0] min1 [4];
  logic [METRIC_W-1:0] min2 [2];
  logic [METRIC_W-1:0] min_pm;

  always_comb begin
    min1[0] = (pm[1] < pm[0]) ? pm[1] : pm[0];
    min1[1] = (pm[3] < pm[2]) ? pm[3] : pm[2];
    min1[2] = (pm[5] < pm[4]) ? pm[5] : pm[4];
    min1[3] = (pm[7] < pm[6]) ? pm[7] : pm[6];
    min2[0] = (min1[1] < min1[0]) ? min1[1] : min1[0];
    min2[1] = (min1[3] < min1[2]) ? min1[3] : min1[2];
    min_pm  = (min2[1] < min2[0]) ? min2[1] : min2[0];
  end

`ifdef VITERBI_BEST_STATE_EN
  // Argmin rides on the same compare tree; the lower half wins ties at every
  // level, so the overall tie-break is the lowest state index.
  logic [2:0] arg1 [4];
  logic [2:0] arg2 [2];

  always_comb begin
    arg1[0]   = (pm[1] < pm[0]) ? 3'd1 : 3'd0;
    arg1[1]   = (pm[3] < pm[2]) ? 3'd3 : 3'd2;
    arg1[2]   = (pm[5] < pm[4]) ? 3'd5 : 3'd4;
    arg1[3]   = (pm[7] < pm[6]) ? 3'd7 : 3'd6;
    arg2[0]   = (min1[1] < min1[0]) ? arg1[1] : arg1[0];
    arg2[1]   = (min1[3] < min1[2]) ? arg1[3] : arg1[2];
    sel_state = (min2[1] < min2[0]) ? arg2[1] : arg2[0];
  end
`else
  assign sel_state = 3'd0;
`endif

  // Per-state ACS, metric register and survivor register.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_state
    logic [METRIC_W-1:0] pm_acs;
    logic                dec;

    viterbi_acs #(
      .METRIC_W (METRIC_W)
    ) u_acs (
      .pm0    (pm[PRED0[g]]),
      .pm1    (pm[PRED1[g]]),
      .d_in   (d_in),
      .sym0   (PSYM0[g]),
      .sym1   (PSYM1[g]),
      .pm_new (pm_acs),
      .sel    (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pm[g]   <= {METRIC_W{g != 0}};
        surv[g] <= '0;
      end else if (!enable_i) begin
        // Survivors are don't-care between frames and are left untouched.
        pm[g] <= {METRIC_W{g != 0}};
      end else begin
        // pm_acs >= min_pm always holds, so this subtraction never wraps.
        pm[g]   <= pm_acs - min_pm;
        surv[g] <= dec ? {surv[PRED1[g]][TB_DEPTH-2:0], PBIT1[g]}
                       : {surv[PRED0[g]][TB_DEPTH-2:0], PBIT0[g]};
      end
    end
  end

  assign full = (fill == FILL_FULL);

  // Output uses the pre-update fill and survivors: symbol TB_DEPTH+j yields bit j.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill    <= '0;
      valid_o <= 1'b0;
      d_out   <= 1'b0;
    end else begin
      valid_o <= enable_i & full;
      d_out   <= enable_i & full & surv[sel_state][TB_DEPTH-1];
      if (!enable_i) begin
        fill <= '0;
      end else if (!full) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Testbench for viterbi_decoder: fixed vector table, hand-written reset
// sequences, and randomised encoded frames with injected bit errors checked
// against a traceback-based reference decoder.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int METRIC_W = 6;
  localparam int PM_MAX   = (1 << METRIC_W) - 1;
`ifdef VITERBI_BEST_STATE_EN
  localparam bit BEST_STATE = 1'b1;
`else
  localparam bit BEST_STATE = 1'b0;
`endif

  // Code definition: [current state][input bit] -> next state / symbol {c1,c0}.
  localparam int NEXT_ST [8][2] = '{'{0,4}, '{4,0}, '{5,1}, '{1,5}, '{2,6}, '{6,2}, '{7,3}, '{3,7}};
  localparam int SYM     [8][2] = '{'{0,3}, '{0,3}, '{2,1}, '{2,1}, '{2,1}, '{2,1}, '{0,3}, '{0,3}};

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic [1:0] d_in;
  logic       valid_o;
  logic       d_out;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  viterbi_decoder #(
    .TB_DEPTH (TB_DEPTH),
    .METRIC_W (METRIC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .d_in     (d_in),
    .valid_o  (valid_o),
    .d_out    (d_out)
  );

  // ---------------- reference decoder ----------------
  // Forward pass records, per step and per state, the winning predecessor and
  // input bit; outputs are recovered by tracing back TB_DEPTH steps.
  int m_pm [8];
  int m_k;
  int h_pred [0:1023][0:7];
  int h_bit  [0:1023][0:7];

  function automatic int hd2(input int a, input int b);
    int x;
    x = (a ^ b) & 3;
    return (x & 1) + (x >> 1);
  endfunction

  task automatic model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < 8; i++) m_pm[i] = PM_MAX;
    m_k = 0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] sym, output logic ev, output logic ed);
    int minv;
    int mini;
    int s;
    int c;
    int ns;
    int nw [8];
    ev = 1'b0;
    ed = 1'b0;
    if (!en) begin
      model_reset();
      return;
    end
    minv = m_pm[0];
    mini = 0;
    for (int i = 1; i < 8; i++) begin
      if (m_pm[i] < minv) begin
        minv = m_pm[i];
        mini = i;
      end
    end
    if (m_k >= TB_DEPTH) begin
      ev = 1'b1;
      s  = BEST_STATE ? mini : 0;
      for (int t = m_k - 1; t >= m_k - TB_DEPTH; t--) begin
        ed = (h_bit[t][s] != 0);
        s  = h_pred[t][s];
      end
    end
    for (int i = 0; i < 8; i++) nw[i] = PM_MAX + 100;
    // Ascending source-state order with strict '<' keeps the lower-index predecessor on ties.
    for (int st = 0; st < 8; st++) begin
      for (int b = 0; b < 2; b++) begin
        ns = NEXT_ST[st][b];
        c  = m_pm[st] + hd2(int'(sym), SYM[st][b]);
        if (c > PM_MAX) c = PM_MAX;
        if (c < nw[ns]) begin
          nw[ns]        = c;
          h_pred[m_k][ns] = st;
          h_bit[m_k][ns]  = b;
        end
      end
    end
    for (int i = 0; i < 8; i++) m_pm[i] = nw[i] - minv;
    if (m_k < 1023) m_k++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk_bit(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] sym);
    enable_i = en;
    d_in     = sym;
    @(posedge clk);
    #1;
  endtask

  // Encoder input 1,0,1,1 then zeros -> 11,10,01,11,00,...; corrupt flips symbol 2 to 00.
  function automatic logic [1:0] frame_a_sym(input int i, input bit corrupt);
    case (i)
      0:       return 2'b11;
      1:       return corrupt ? 2'b00 : 2'b10;
      2:       return 2'b01;
      3:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic frame_a_bit(input int j);
    case (j)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic       en;
    logic [1:0] sym;
    logic       ev;
    logic       ed;
  } vec_t;

  vec_t vt [$];

  function automatic void add_vec(input logic en, input logic [1:0] sym, input logic ev, input logic ed);
    vec_t v;
    v.en  = en;
    v.sym = sym;
    v.ev  = ev;
    v.ed  = ed;
    vt.push_back(v);
  endfunction

  task automatic run_random(input int nbits, input int id);
    int         es;
    int         b;
    int         outs;
    int         err_at;
    logic [1:0] sym;
    logic       ev;
    logic       ed;
    es     = 0;
    outs   = 0;
    err_at = -1;
    for (int i = 0; i < nbits + TB_DEPTH; i++) begin
      b   = (i < nbits) ? int'($urandom_range(0, 1)) : 0;
      sym = 2'(SYM[es][b]);
      es  = NEXT_ST[es][b];
      if (i % 20 == 0) err_at = i + int'($urandom_range(0, 19));
      if (i == err_at) sym = sym ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      drive(1'b1, sym);
      model_step(1'b1, sym, ev, ed);
      chk_bit("rnd_valid", i, valid_o, ev);
      chk_bit("rnd_dout", i, d_out, ed);
      if (valid_o === 1'b1) outs++;
    end
    chk_int("rnd_count", id, outs, nbits);
    drive(1'b0, 2'b00);
    model_step(1'b0, 2'b00, ev, ed);
    chk_bit("rnd_idle_valid", id, valid_o, ev);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    enable_i = 1'b0;
    d_in     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset_valid", 0, valid_o, 1'b0);
    chk_bit("reset_dout", 0, d_out, 1'b0);
    rst = 1'b1;

    // Frame A clean, then frame A with one symbol error; each closed by an idle cycle.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 20; i++)
        add_vec(1'b1, frame_a_sym(i, f == 1), i >= 16, (i >= 16) ? frame_a_bit(i - 16) : 1'b0);
      add_vec(1'b0, 2'b00, 1'b0, 1'b0);
    end
    // All-zero stream for 40 symbols, one idle, then refill needs 16 more symbols.
    for (int i = 0; i < 40; i++) add_vec(1'b1, 2'b00, i >= 16, 1'b0);
    add_vec(1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) add_vec(1'b1, 2'b00, i == 16, 1'b0);
    add_vec(1'b0, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].en, vt[i].sym);
      chk_bit("tbl_valid", i, valid_o, vt[i].ev);
      chk_bit("tbl_dout", i, d_out, vt[i].ed);
    end

    // Reset pulse mid-frame at symbol 10, then a full frame must decode from scratch.
    for (int i = 0; i < 10; i++) drive(1'b1, frame_a_sym(i, 1'b0));
    rst = 1'b0;
    #2;
    chk_bit("midrst_valid", 10, valid_o, 1'b0);
    chk_bit("midrst_dout", 10, d_out, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, frame_a_sym(i, 1'b0));
      chk_bit("after_rst_valid", i, valid_o, i >= 16);
      chk_bit("after_rst_dout", i, d_out, (i >= 16) ? frame_a_bit(i - 16) : 1'b0);
    end
    drive(1'b0, 2'b00);

    // Reset while a decoded 1 is on the output: must clear before the next edge.
    for (int i = 0; i <= 16; i++) drive(1'b1, frame_a_sym(i, 1'b0));
    chk_bit("live_valid", 16, valid_o, 1'b1);
    chk_bit("live_dout", 16, d_out, 1'b1);
    enable_i = 1'b0;
    rst      = 1'b0;
    #2;
    chk_bit("async_clr_valid", 0, valid_o, 1'b0);
    chk_bit("async_clr_dout", 0, d_out, 1'b0);
    rst = 1'b1;
    drive(1'b0, 2'b00);

    // Randomised encoded frames with one bit error per 20 symbols.
    model_reset();
    run_random(500, 0);
    for (int f = 1; f <= 3; f++) run_random(int'($urandom_range(TB_DEPTH, 60)), f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
